// File: rtl/clk_div_mon_pkg.sv
// Shared definitions for the divided-clock monitor.
//   mon_state_t    : monitor FSM states
//   DEF_*          : default parameter values
//   hi_pair_t      : the two accepted high times for a given ratio
//   accepted_high(): computes hi_pair_t from an expected divide ratio
package clk_div_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED,
        FAULT
    } mon_state_t;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_LOCK_CNT    = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Width of the consecutive-match counter; LOCK_CNT is limited to 1..15.
    localparam int unsigned MATCH_W = 4;

    typedef struct packed {
        logic [31:0] hi_lo;
        logic [31:0] hi_hi;
    } hi_pair_t;

    // Even ratios accept exactly half; odd ratios accept floor or ceil of half.
    function automatic hi_pair_t accepted_high(input logic [31:0] ratio);
        hi_pair_t p;
        p.hi_lo = ratio >> 1;
        p.hi_hi = (ratio >> 1) + {31'd0, ratio[0]};
        return p;
    endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Synchroniser chain plus edge detector for a signal sampled as data.
//   clk, rst_n : clock and asynchronous active-low reset
//   d_in       : asynchronous input
//   d_s        : synchronised level (after SYNC_STAGES flops)
//   rise, fall : single-cycle edge strobes of d_s against its delayed copy
module edge_sync_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            d_q    <= 1'b0;
        end else begin
            sync_q[0] <= d_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign d_s  = sync_q[SYNC_STAGES-1];
    assign rise = d_s & ~d_q;
    assign fall = ~d_s & d_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Checks a divided clock (sampled as data in the source clock domain):
// measures period and high time, locks after LOCK_CNT consecutive good
// periods and raises a sticky fault on mismatch after lock or on a stall.
//   clk, rst_n   : source clock, asynchronous active-low reset
//   en           : monitor enable, low forces IDLE
//   div_in       : divided clock under test
//   exp_ratio    : expected divide ratio (change only while en=0)
//   clr_fault    : single-cycle pulse, FAULT -> ARM
//   meas_period  : last complete period in clk cycles
//   meas_high    : high time of that period in clk cycles
//   period_valid : single-cycle pulse when meas_* update
//   locked       : ratio and duty confirmed
//   fault        : sticky error flag
module clk_div_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_ratio,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);

    logic d_s;
    logic rise;
    logic fall;

    logic [CNT_W-1:0]   per_cnt;
    logic [CNT_W-1:0]   hi_cnt;
    logic [CNT_W-1:0]   hi_lat;
    logic [MATCH_W-1:0] match_cnt;
    logic [MATCH_W-1:0] match_nxt;

    mon_state_t state;
    mon_state_t state_nxt;

    hi_pair_t hp;
    logic     hi_ok;
    logic     match;
    logic     timeout;
    logic     measuring;

    edge_sync_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (div_in),
        .d_s  (d_s),
        .rise (rise),
        .fall (fall)
    );

    // Rise restarts per_cnt, so a rise and a timeout are mutually exclusive.
    assign timeout = (per_cnt == CNT_MAX) && !rise;

    assign hp    = accepted_high(32'(exp_ratio));
    assign hi_ok = (32'(hi_lat) == hp.hi_lo) || (32'(hi_lat) == hp.hi_hi);
    assign match = (exp_ratio >= CNT_W'(2)) && (per_cnt == exp_ratio) && hi_ok;

    // The first rise after ARM only aligns the counters; it closes no period.
    assign measuring = rise && (state == MEASURE || state == LOCKED || state == FAULT);

    // Period and high-time counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            hi_lat  <= '0;
        end else if (state == IDLE) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            hi_lat  <= '0;
        end else begin
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else begin
                if (per_cnt != CNT_MAX) begin
                    per_cnt <= per_cnt + CNT_W'(1);
                end
                if (d_s && (hi_cnt != CNT_MAX)) begin
                    hi_cnt <= hi_cnt + CNT_W'(1);
                end
            end
            if (fall) begin
                hi_lat <= hi_cnt;
            end
        end
    end

    // Measurement outputs; cleared on the edge where en drops so the
    // outputs read zero together with locked/fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_period  <= '0;
            meas_high    <= '0;
            period_valid <= 1'b0;
        end else if (!en || state == IDLE) begin
            meas_period  <= '0;
            meas_high    <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= measuring;
            if (measuring) begin
                meas_period <= per_cnt;
                meas_high   <= hi_lat;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        if (!en) begin
            state_nxt = IDLE;
            match_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    match_nxt = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        match_nxt = '0;
                    end else if (timeout) begin
                        state_nxt = FAULT;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (match) begin
                            match_nxt = match_cnt + MATCH_W'(1);
                            if ((match_cnt + MATCH_W'(1)) == LOCK_TGT) begin
                                state_nxt = LOCKED;
                            end
                        end else begin
                            match_nxt = '0;
                        end
                    end else if (timeout) begin
                        state_nxt = FAULT;
                    end
                end
                LOCKED: begin
                    if ((rise && !match) || timeout) begin
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    if (clr_fault) begin
                        state_nxt = ARM;
                        match_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    match_nxt = '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;

    localparam int unsigned CNT_W = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             en        = 1'b0;
    logic             div_in    = 1'b0;
    logic             clr_fault = 1'b0;
    logic [CNT_W-1:0] exp_ratio = '0;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             period_valid;
    logic             locked;
    logic             fault;

    int errors = 0;
    int checks = 0;

    int   cyc            = 0;
    int   pv_count       = 0;
    int   last_pv_cyc    = 0;
    int   last_period    = 0;
    int   last_high      = 0;
    logic last_pv_locked = 1'b0;
    logic last_pv_fault  = 1'b0;

    always #5 clk = ~clk;

    clk_div_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_CNT   (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_in      (div_in),
        .exp_ratio   (exp_ratio),
        .clr_fault   (clr_fault),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault)
    );

    always @(posedge clk) cyc++;

    // Record every measurement and the status outputs seen alongside it.
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            pv_count++;
            last_pv_cyc    = cyc;
            last_period    = int'(meas_period);
            last_high      = int'(meas_high);
            last_pv_locked = locked;
            last_pv_fault  = fault;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // One div_in period: hi cycles high then lo cycles low, stepped on negedges.
    task automatic drive(input int hi, input int lo);
        div_in = 1'b1;
        repeat (hi) @(negedge clk);
        div_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic restart(input logic [CNT_W-1:0] ratio);
        en = 1'b0;
        @(negedge clk);
        exp_ratio = ratio;
        en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        int k;

        repeat (2) @(negedge clk);
        check("rst_locked", 32'(locked), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_pv", 32'(period_valid), 0);
        check("rst_period", 32'(meas_period), 0);
        check("rst_high", 32'(meas_high), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Divide-by-4, 2 high / 2 low: lock on the 5th rise.
        restart(8'd4);
        repeat (4) drive(2, 2);
        check("d4_prelock", 32'(locked), 0);
        check("d4_pv_cnt3", 32'(pv_count), 3);
        drive(2, 2);
        check("d4_locked", 32'(locked), 1);
        check("d4_pv_cnt4", 32'(pv_count), 4);
        check("d4_period", 32'(last_period), 4);
        check("d4_high", 32'(last_high), 2);
        check("d4_meas_out", 32'(meas_period), 4);

        // One short period (2 high / 1 low) while locked.
        drive(2, 1);
        drive(2, 2);
        check("short_period", 32'(last_period), 3);
        check("short_pv_fault", 32'(last_pv_fault), 1);
        check("short_pv_locked", 32'(last_pv_locked), 0);
        check("short_fault", 32'(fault), 1);
        repeat (3) drive(2, 2);
        check("sticky_fault", 32'(fault), 1);
        check("sticky_locked", 32'(locked), 0);
        check("sticky_period", 32'(last_period), 4);

        // clr_fault returns to ARM and the good clock relocks on the 5th rise.
        clr_fault = 1'b1;
        @(negedge clk);
        clr_fault = 1'b0;
        @(negedge clk);
        check("clr_fault", 32'(fault), 0);
        check("clr_locked", 32'(locked), 0);
        repeat (4) drive(2, 2);
        check("relock_pre", 32'(locked), 0);
        drive(2, 2);
        check("relock", 32'(locked), 1);

        // Stalled clock: fault exactly 255 cycles after the last measured rise.
        k = 0;
        while (fault !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("to_fault", 32'(fault), 1);
        check("to_locked", 32'(locked), 0);
        check("to_delay", 32'(cyc - last_pv_cyc), 255);

        // en low clears status and measurements on the next edge.
        en = 1'b0;
        @(negedge clk);
        check("en0_locked", 32'(locked), 0);
        check("en0_fault", 32'(fault), 0);
        check("en0_period", 32'(meas_period), 0);

        // Odd ratio 5: both duty splits lock, 1/4 never does.
        restart(8'd5);
        repeat (4) drive(2, 3);
        check("r5a_prelock", 32'(locked), 0);
        drive(2, 3);
        check("r5a_locked", 32'(locked), 1);
        check("r5a_period", 32'(last_period), 5);
        check("r5a_high", 32'(last_high), 2);

        restart(8'd5);
        repeat (5) drive(3, 2);
        check("r5b_locked", 32'(locked), 1);
        check("r5b_high", 32'(last_high), 3);

        restart(8'd5);
        n0 = pv_count;
        repeat (8) drive(1, 4);
        check("r5c_locked", 32'(locked), 0);
        check("r5c_fault", 32'(fault), 0);
        check("r5c_high", 32'(last_high), 1);
        check("r5c_pv_cnt", 32'(pv_count - n0), 7);

        // Ratio below 2 never locks and never faults on a running clock.
        restart(8'd0);
        repeat (6) drive(2, 2);
        check("r0_locked", 32'(locked), 0);
        check("r0_fault", 32'(fault), 0);

        // Asynchronous reset while locked.
        restart(8'd4);
        repeat (5) drive(2, 2);
        check("arst_pre_locked", 32'(locked), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_fault", 32'(fault), 0);
        check("arst_period", 32'(meas_period), 0);
        check("arst_high", 32'(meas_high), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        repeat (4) drive(2, 2);
        check("arst_relock_pre", 32'(locked), 0);
        drive(2, 2);
        check("arst_relock", 32'(locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
